// File: rtl/myproject_mac_pkg.sv
// myproject_mac_pkg: shared mode encodings and the output resize helper for the MAC pipe
package myproject_mac_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;
    localparam int   MAX_W    = 64;

    // Returns {ovf, result}: result is value itself, or value clamped to the signed dout_w range
    // when sat_en is set; callers keep the dout_w LSBs, which also gives two's-complement wrap.
    function automatic logic [MAX_W:0] sat_resize(input logic signed [MAX_W-1:0] value,
                                                  input int dout_w, input logic sat_en);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        logic                    ovf;
        hi  = $signed((MAX_W'(1) << (dout_w - 1)) - MAX_W'(1));
        lo  = ~hi;
        ovf = (value > hi) || (value < lo);
        return {ovf, (sat_en && ovf) ? (value[MAX_W-1] ? lo : hi) : value};
    endfunction

endpackage

// File: rtl/myproject_mac_lane.sv
// myproject_mac_lane: one lane of the MAC pipe (product register, delay stages, accumulator, resize)
module myproject_mac_lane
    import myproject_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 26,
    parameter int ACC_WIDTH  = 40,
    parameter int NUM_STAGE  = 2,
    parameter int SAT_EN     = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         adv,
    input  logic                         fin_fire,
    input  logic                         fin_acc,
    input  logic                         fin_last,
    input  logic signed [DIN0_WIDTH-1:0] a,
    input  logic signed [DIN1_WIDTH-1:0] b,
    output logic        [DOUT_WIDTH-1:0] dout,
    output logic                         ovf
);

    localparam int P = DIN0_WIDTH + DIN1_WIDTH;

    logic signed [P-1:0]         prod_q [NUM_STAGE];
    logic signed [P-1:0]         prod_d [NUM_STAGE];
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic signed [ACC_WIDTH-1:0] sum;
    logic        [MAX_W:0]       rs;

    // Shift the product pipe on advance; the final-stage product either folds into acc or leaves as a result.
    always_comb begin
        prod_d = prod_q;
        if (adv) begin
            prod_d[0] = a * b;
            for (int i = 1; i < NUM_STAGE; i++) prod_d[i] = prod_q[i-1];
        end
        sum   = fin_acc ? acc_q + ACC_WIDTH'(prod_q[NUM_STAGE-1]) : ACC_WIDTH'(prod_q[NUM_STAGE-1]);
        acc_d = fin_fire ? ((fin_acc && !fin_last) ? sum : '0) : acc_q;
        rs    = sat_resize(MAX_W'(sum), DOUT_WIDTH, SAT_EN != 0);
        dout  = DOUT_WIDTH'(rs);
        ovf   = rs[MAX_W];
    end

    // Product pipe and accumulator; reset discards in-flight products and partial sums.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
            acc_q <= '0;
        end else begin
            prod_q <= prod_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined multi-lane signed multiply / multiply-accumulate with valid/ready
module myproject_mac_pipe
    import myproject_mac_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 16,
    parameter int DOUT_WIDTH = 26,
    parameter int ACC_WIDTH  = 40,
    parameter int NUM_STAGE  = 2,
    parameter int SAT_EN     = 0
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic                          mode,
    input  logic [LANES*DIN0_WIDTH-1:0]   din0,
    input  logic [LANES*DIN1_WIDTH-1:0]   din1,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic [LANES*DOUT_WIDTH-1:0]   dout,
    output logic [LANES-1:0]              ovf
);

    logic [NUM_STAGE-1:0] vld_q, vld_d;
    logic [NUM_STAGE-1:0] mode_q, mode_d;
    logic [NUM_STAGE-1:0] last_q, last_d;
    logic                 stall;
    logic                 fin_fire;

    // All stages move together unless a finished result is blocked downstream; non-last
    // accumulate beats never stall because they produce no output.
    always_comb begin
        out_valid = vld_q[NUM_STAGE-1] && (mode_q[NUM_STAGE-1] == MODE_MUL || last_q[NUM_STAGE-1]);
        out_last  = vld_q[NUM_STAGE-1] && mode_q[NUM_STAGE-1] == MODE_ACC && last_q[NUM_STAGE-1];
        stall     = out_valid && !out_ready;
        in_ready  = !stall;
        fin_fire  = vld_q[NUM_STAGE-1] && !stall;
        vld_d     = stall ? vld_q  : NUM_STAGE'({vld_q, in_valid});
        mode_d    = stall ? mode_q : NUM_STAGE'({mode_q, mode});
        last_d    = stall ? last_q : NUM_STAGE'({last_q, in_last});
    end

    // Stage valid / mode / last shift registers.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_q  <= '0;
            mode_q <= '0;
            last_q <= '0;
        end else begin
            vld_q  <= vld_d;
            mode_q <= mode_d;
            last_q <= last_d;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        myproject_mac_lane #(
            .DIN0_WIDTH(DIN0_WIDTH),
            .DIN1_WIDTH(DIN1_WIDTH),
            .DOUT_WIDTH(DOUT_WIDTH),
            .ACC_WIDTH (ACC_WIDTH),
            .NUM_STAGE (NUM_STAGE),
            .SAT_EN    (SAT_EN)
        ) u_lane (
            .clk     (ap_clk),
            .rst_n   (ap_rst_n),
            .adv     (!stall),
            .fin_fire(fin_fire),
            .fin_acc (mode_q[NUM_STAGE-1] == MODE_ACC),
            .fin_last(last_q[NUM_STAGE-1]),
            .a       (din0[g*DIN0_WIDTH +: DIN0_WIDTH]),
            .b       (din1[g*DIN1_WIDTH +: DIN1_WIDTH]),
            .dout    (dout[g*DOUT_WIDTH +: DOUT_WIDTH]),
            .ovf     (ovf[g])
        );
    end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// tb_myproject_mac_pipe: directed and randomized checks of the MAC pipe in three configurations
module tb_myproject_mac_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_last, mode, out_ready;
    logic [63:0]  din0, din1;
    logic         ir_a, ir_b, ir_c, ov_a, ov_b, ov_c, ol_a, ol_b, ol_c;
    logic [103:0] dq_a, dq_b;
    logic [25:0]  dq_c;
    logic [3:0]   of_a, of_b;
    logic [0:0]   of_c;
    logic [2:0]   ir, ov, ol;

    assign ir = {ir_c, ir_b, ir_a};
    assign ov = {ov_c, ov_b, ov_a};
    assign ol = {ol_c, ol_b, ol_a};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [103:0] d;
        logic [3:0]   o;
        logic         l;
    } exp_t;

    exp_t   q [3][$];
    longint macc [3][4];

    // A: 4 lanes, 2 stages, wrap.  B: 4 lanes, 3 stages, saturate.  C: 1 lane, 1 stage, wrap.
    myproject_mac_pipe #(.LANES(4), .NUM_STAGE(2), .SAT_EN(0)) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_a), .in_last(in_last),
        .mode(mode), .din0(din0), .din1(din1), .out_valid(ov_a), .out_ready(out_ready),
        .out_last(ol_a), .dout(dq_a), .ovf(of_a));

    myproject_mac_pipe #(.LANES(4), .NUM_STAGE(3), .SAT_EN(1)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_b), .in_last(in_last),
        .mode(mode), .din0(din0), .din1(din1), .out_valid(ov_b), .out_ready(out_ready),
        .out_last(ol_b), .dout(dq_b), .ovf(of_b));

    myproject_mac_pipe #(.LANES(1), .NUM_STAGE(1), .SAT_EN(0)) dut_c (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_c), .in_last(in_last),
        .mode(mode), .din0(din0[15:0]), .din1(din1[15:0]), .out_valid(ov_c), .out_ready(out_ready),
        .out_last(ol_c), .dout(dq_c), .ovf(of_c));

    function automatic logic [103:0] dsel(input int k);
        return k == 0 ? dq_a : k == 1 ? dq_b : {78'd0, dq_c};
    endfunction

    function automatic logic [3:0] osel(input int k);
        return k == 0 ? of_a : k == 1 ? of_b : {3'd0, of_c};
    endfunction

    // Reference resize of an exact integer to 26 bits: {ovf, result}.
    function automatic logic [26:0] mdl_resize(input longint v, input bit sat);
        longint hi = 64'sd33554431;
        longint lo = -64'sd33554432;
        longint r;
        r = (sat && v > hi) ? hi : (sat && v < lo) ? lo : v;
        return {v > hi || v < lo, r[25:0]};
    endfunction

    // Reference behaviour for one accepted beat on configuration k.
    task automatic model_beat(input int k);
        exp_t        e;
        longint      p, s;
        logic [26:0] r;
        bit          emit;
        e    = '{d: '0, o: '0, l: 1'b0};
        emit = !mode || in_last;
        e.l  = mode && in_last;
        for (int i = 0; i < (k == 2 ? 1 : 4); i++) begin
            p = longint'($signed(din0[i*16 +: 16])) * longint'($signed(din1[i*16 +: 16]));
            s = mode ? ((macc[k][i] + p) <<< 24) >>> 24 : p;
            macc[k][i] = emit ? 64'sd0 : s;
            r = mdl_resize(s, k == 1);
            e.d[i*26 +: 26] = r[25:0];
            e.o[i] = r[26];
        end
        if (emit) q[k].push_back(e);
    endtask

    task automatic idle();
        in_valid = 1'b0; in_last = 1'b0; mode = 1'b0; din0 = '0; din1 = '0; out_ready = 1'b1;
    endtask

    // Drives an accumulate packet of n beats (din0 = a0 + step*beat, din1 = bv on all lanes) on A.
    task automatic run_acc(input int n, input int a0, input int step, input int bv, input bit toggle,
                           output int nres, output logic [103:0] d, output logic l);
        int sent = 0;
        nres = 0; d = '0; l = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            out_ready = toggle ? (c % 2 == 1) : 1'b1;
            in_valid  = sent < n;
            mode      = 1'b1;
            in_last   = sent == n - 1;
            for (int i = 0; i < 4; i++) begin
                din0[i*16 +: 16] = 16'(a0 + step * sent);
                din1[i*16 +: 16] = 16'(bv);
            end
            #1;
            if (ov_a && out_ready) begin nres++; d = dq_a; l = ol_a; end
            if (in_valid && ir_a) sent++;
        end
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({ov[k], ol[k], ir[k]} !== 3'b001 || dsel(k) !== '0 || osel(k) !== '0) begin
                errors++;
                $display("FAIL reset dut%0d got v/l/r=%b%b%b dout=%h ovf=%b want 001 0 0", k, ov[k], ol[k], ir[k], dsel(k), osel(k));
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_mul_basic();
        idle();
        @(negedge clk);
        in_valid = 1'b1;
        din0[15:0] = 16'(-300);
        din1[15:0] = 16'd200;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (ov_a !== 1'b0) begin errors++; $display("FAIL mul_latency early out_valid got %b want 0", ov_a); end
        @(negedge clk);
        checks++;
        if (ov_a !== 1'b1 || dq_a[25:0] !== 26'(-60000) || of_a[0] !== 1'b0) begin
            errors++;
            $display("FAIL mul_basic got v=%b dout0=%0d ovf0=%b want v=1 dout0=-60000 ovf0=0", ov_a, $signed(dq_a[25:0]), of_a[0]);
        end
        @(negedge clk);
    endtask

    task automatic test_mul_ovf();
        idle();
        @(negedge clk);
        in_valid = 1'b1;
        din0[31:16] = 16'd32767;
        din1[31:16] = 16'd32767;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ov_a !== 1'b1 || dq_a[51:26] !== 26'(-65535) || of_a !== 4'b0010) begin
            errors++;
            $display("FAIL mul_wrap got v=%b dout1=%0d ovf=%b want v=1 dout1=-65535 ovf=0010", ov_a, $signed(dq_a[51:26]), of_a);
        end
        @(negedge clk);
        checks++;
        if (ov_b !== 1'b1 || dq_b[51:26] !== 26'd33554431 || of_b !== 4'b0010) begin
            errors++;
            $display("FAIL mul_sat got v=%b dout1=%0d ovf=%b want v=1 dout1=33554431 ovf=0010", ov_b, $signed(dq_b[51:26]), of_b);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic signed [15:0] a [10];
        logic signed [15:0] b [10];
        int          sent = 0, got = 0;
        bit          blocked = 0, pstall = 0;
        logic [25:0] pd = '0;
        for (int i = 0; i < 10; i++) begin a[i] = 16'($urandom); b[i] = 16'($urandom); end
        idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            out_ready  = !(c >= 3 && c <= 7);
            in_valid   = sent < 10;
            din0[15:0] = a[sent % 10];
            din1[15:0] = b[sent % 10];
            #1;
            if (!ir_a) blocked = 1;
            if (pstall) begin
                checks++;
                if (ov_a !== 1'b1 || dq_a[25:0] !== pd) begin
                    errors++;
                    $display("FAIL bp_hold got v=%b dout0=%h want v=1 dout0=%h", ov_a, dq_a[25:0], pd);
                end
            end
            if (ov_a && out_ready) begin
                checks++;
                if (got >= 10 || dq_a[25:0] !== 26'(int'(a[got % 10]) * int'(b[got % 10]))) begin
                    errors++;
                    $display("FAIL bp_order result %0d got %h want %h", got, dq_a[25:0], 26'(int'(a[got % 10]) * int'(b[got % 10])));
                end
                got++;
            end
            if (in_valid && ir_a) sent++;
            pstall = ov_a && !out_ready;
            pd     = dq_a[25:0];
        end
        checks++;
        if (got != 10 || !blocked) begin
            errors++;
            $display("FAIL bp_count got results=%0d in_ready_fell=%0d want 10 and 1", got, blocked);
        end
        idle();
    endtask

    task automatic test_acc();
        int           n;
        logic [103:0] d;
        logic         l;
        run_acc(4, 1, 1, 10, 1'b1, n, d, l);
        checks++;
        if (n != 1 || d !== {4{26'd100}} || l !== 1'b1) begin
            errors++;
            $display("FAIL acc_packet got n=%0d dout=%h last=%b want n=1 dout=%h last=1", n, d, l, {4{26'd100}});
        end
        run_acc(1, 3, 0, 7, 1'b0, n, d, l);
        checks++;
        if (n != 1 || d !== {4{26'd21}} || l !== 1'b1) begin
            errors++;
            $display("FAIL acc_restart got n=%0d dout=%h last=%b want n=1 dout=%h last=1", n, d, l, {4{26'd21}});
        end
    endtask

    task automatic test_reset_mid();
        int           n;
        logic [103:0] d;
        logic         l;
        idle();
        @(negedge clk);
        in_valid = 1'b1; mode = 1'b1; din0 = {4{16'd7}}; din1 = {4{16'd7}};
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || ol[k] !== 1'b0 || dsel(k) !== '0 || osel(k) !== '0) begin
                errors++;
                $display("FAIL reset_mid dut%0d got v=%b l=%b dout=%h ovf=%b want all 0", k, ov[k], ol[k], dsel(k), osel(k));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_acc(3, 5, 0, 5, 1'b0, n, d, l);
        checks++;
        if (n != 1 || d !== {4{26'd75}} || l !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart got n=%0d dout=%h last=%b want n=1 dout=%h last=1", n, d, l, {4{26'd75}});
        end
    endtask

    task automatic test_throughput();
        int first = -1, lastc = -1, cnt = 0;
        idle();
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            in_valid   = c < 8;
            din0[15:0] = 16'(c + 1);
            din1[15:0] = 16'd3;
            #1;
            if (c < 8) begin
                checks++;
                if (ir_a !== 1'b1) begin errors++; $display("FAIL tput_ready cycle %0d got %b want 1", c, ir_a); end
            end
            if (ov_a) begin
                if (first < 0) first = c;
                lastc = c;
                cnt++;
                checks++;
                if (dq_a[25:0] !== 26'(3 * cnt)) begin
                    errors++;
                    $display("FAIL tput_data result %0d got %0d want %0d", cnt, dq_a[25:0], 3 * cnt);
                end
            end
        end
        checks++;
        if (cnt != 8 || first != 2 || lastc - first != 7) begin
            errors++;
            $display("FAIL tput_rate got n=%0d first=%0d span=%0d want 8 2 7", cnt, first, lastc - first);
        end
        idle();
    endtask

    task automatic test_random();
        logic [2:0]   pstall = '0, pl = '0;
        logic [103:0] pd [3];
        logic [3:0]   po [3];
        exp_t         e;
        idle();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            for (int i = 0; i < 4; i++) macc[k][i] = 0;
        end
        for (int c = 0; c < 1610; c++) begin
            @(negedge clk);
            if (c < 1600) begin
                in_valid  = $urandom_range(0, 4) != 0;
                mode      = $urandom_range(0, 2) != 0;
                in_last   = $urandom_range(0, 3) == 0;
                out_ready = $urandom_range(0, 3) != 0;
                din0 = {$urandom, $urandom};
                din1 = {$urandom, $urandom};
                for (int i = 0; i < 4; i++) begin
                    if ($urandom_range(0, 1) == 1) din0[i*16 +: 16] = 16'($signed(din0[i*16 +: 8]));
                    if ($urandom_range(0, 1) == 1) din1[i*16 +: 16] = 16'($signed(din1[i*16 +: 8]));
                end
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (ir[k] !== !(ov[k] && !out_ready)) begin
                    errors++;
                    $display("FAIL rnd_ready dut%0d cycle %0d got %b want %b", k, c, ir[k], !(ov[k] && !out_ready));
                end
                if (pstall[k]) begin
                    checks++;
                    if (ov[k] !== 1'b1 || dsel(k) !== pd[k] || osel(k) !== po[k] || ol[k] !== pl[k]) begin
                        errors++;
                        $display("FAIL rnd_hold dut%0d cycle %0d got v=%b dout=%h want v=1 dout=%h", k, c, ov[k], dsel(k), pd[k]);
                    end
                end
                if (ov[k] && out_ready) begin
                    checks++;
                    if (q[k].size() == 0) begin
                        errors++;
                        $display("FAIL rnd_extra dut%0d cycle %0d got unexpected result %h want none", k, c, dsel(k));
                    end else begin
                        e = q[k].pop_front();
                        if (dsel(k) !== e.d || osel(k) !== e.o || ol[k] !== e.l) begin
                            errors++;
                            $display("FAIL rnd_data dut%0d cycle %0d got dout=%h ovf=%b last=%b want dout=%h ovf=%b last=%b",
                                     k, c, dsel(k), osel(k), ol[k], e.d, e.o, e.l);
                        end
                    end
                end
                if (in_valid && ir[k]) model_beat(k);
                pstall[k] = ov[k] && !out_ready;
                pd[k] = dsel(k);
                po[k] = osel(k);
                pl[k] = ol[k];
            end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL rnd_missing dut%0d got %0d results outstanding want 0", k, q[k].size());
            end
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        test_reset();
        test_mul_basic();
        test_mul_ovf();
        test_backpressure();
        test_acc();
        test_reset_mid();
        test_throughput();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
